exc_irq_manager: RTL and testbench

- Sequential exception/interrupt manager for the single-cycle LEGv8 core.
- Edge-detects and latches external interrupt requests, prioritises them against synchronous faults (illegal opcode, stray ERET), saves return state (ELR/ESR) and drives the PC redirect to the exception vector.
- Tracks handler mode until ERET; sits beside the main controller, feeding its ExtIRQ input and consuming its NotAnInstr/ERet decode.

---
 rtl/exc_irq_manager.sv | 81 ++++++++
 tb/tb_exc_irq_manager.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/exc_irq_manager.sv
// exc_irq_manager: latches edge-triggered IRQs, prioritises faults over IRQs, and redirects the PC to the vector or to ELR
module exc_irq_manager #(
  parameter int N = 64,
  parameter int N_IRQ = 4,
  parameter logic [N-1:0] EXC_VECTOR = 64'h00000000000000D8,
  localparam int IW = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_req,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             not_an_instr,
  input  logic             eret,
  input  logic [N-1:0]     pc,
  output logic             ExtIRQ,
  output logic [N_IRQ-1:0] ExtIAck,
  output logic             exc_taken,
  output logic             eret_taken,
  output logic [N-1:0]     exc_vector,
  output logic [N-1:0]     elr,
  output logic [3:0]       esr,
  output logic [IW-1:0]    irq_id,
  output logic             in_handler
);
  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] HANDLER = 1'b1;
  logic [0:0] state;
  logic [N_IRQ-1:0] pending, irq_prev, cand, ack;
  logic [IW-1:0] sel_id;
  logic any, run, fault, take_irq, ret;
  assign cand = pending & irq_mask;
  // lowest-index enabled pending line
  always_comb begin
    sel_id = '0;
    any = 1'b0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (cand[i]) begin
        sel_id = IW'(i);
        any = 1'b1;
      end
  end
  assign run = state == RUN;
  assign fault = not_an_instr | (run & eret);
  assign take_irq = run & ~not_an_instr & ~eret & any;
  assign ret = ~run & eret & ~not_an_instr;
  assign ack = take_irq ? N_IRQ'(1) << sel_id : '0;
  assign ExtIRQ = ~reset & take_irq;
  assign ExtIAck = reset ? '0 : ack;
  assign exc_taken = ~reset & (fault | take_irq);
  assign eret_taken = ~reset & ret;
  assign exc_vector = EXC_VECTOR;
  assign in_handler = state == HANDLER;
  // request latching plus RUN/HANDLER sequencing with ELR/ESR capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      pending <= '0;
      irq_prev <= '0;
      elr <= '0;
      esr <= '0;
      irq_id <= '0;
    end else begin
      irq_prev <= irq_req;
      pending <= (pending & ~ack) | (irq_req & ~irq_prev);
      if (run && fault) begin
        elr <= pc;
        esr <= 4'b0010;
        state <= HANDLER;
      end else if (take_irq) begin
        elr <= pc + N'(4);
        esr <= 4'b0001;
        irq_id <= sel_id;
        state <= HANDLER;
      end else if (!run && not_an_instr) begin
        esr <= 4'b1111;
      end else if (ret) begin
        state <= RUN;
      end
    end
  end
endmodule

// File: tb/tb_exc_irq_manager.sv
// tb_exc_irq_manager: directed checks of IRQ latching, fault priority, handler mode and async reset
module tb_exc_irq_manager;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] irq_req = '0;
  logic [3:0] irq_mask = 4'hF;
  logic not_an_instr = 1'b0;
  logic eret = 1'b0;
  logic [63:0] pc = '0;
  logic ExtIRQ, exc_taken, eret_taken, in_handler;
  logic [3:0] ExtIAck, esr;
  logic [63:0] exc_vector, elr;
  logic [1:0] irq_id;
  int total = 0;
  int passed = 0;

  exc_irq_manager dut (
    .clk(clk), .reset(reset), .irq_req(irq_req), .irq_mask(irq_mask),
    .not_an_instr(not_an_instr), .eret(eret), .pc(pc), .ExtIRQ(ExtIRQ),
    .ExtIAck(ExtIAck), .exc_taken(exc_taken), .eret_taken(eret_taken),
    .exc_vector(exc_vector), .elr(elr), .esr(esr), .irq_id(irq_id),
    .in_handler(in_handler)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_extirq", ExtIRQ, 0);
    chk("rst_ack", ExtIAck, 0);
    chk("rst_exc", exc_taken, 0);
    chk("rst_eret", eret_taken, 0);
    chk("rst_vec", exc_vector, 64'hD8);
    chk("rst_elr", elr, 0);
    chk("rst_esr", esr, 0);
    chk("rst_id", irq_id, 0);
    chk("rst_hnd", in_handler, 0);
    tick;
    reset = 1'b0;
    tick;
    pc = 64'h40;
    irq_req = 4'b0100;
    tick;
    irq_req = 4'b0000;
    #1;
    chk("t1_extirq", ExtIRQ, 1);
    chk("t1_exc", exc_taken, 1);
    chk("t1_ack", ExtIAck, 4'b0100);
    chk("t1_hnd_pre", in_handler, 0);
    tick;
    chk("t1_elr", elr, 64'h44);
    chk("t1_esr", esr, 1);
    chk("t1_id", irq_id, 2);
    chk("t1_hnd", in_handler, 1);
    chk("t1_ack_once", ExtIAck, 0);
    not_an_instr = 1'b1;
    #1;
    chk("dbl_exc", exc_taken, 1);
    tick;
    not_an_instr = 1'b0;
    #1;
    chk("dbl_esr", esr, 4'hF);
    chk("dbl_elr", elr, 64'h44);
    chk("dbl_hnd", in_handler, 1);
    eret = 1'b1;
    #1;
    chk("dbl_eret_taken", eret_taken, 1);
    chk("dbl_eret_noexc", exc_taken, 0);
    tick;
    eret = 1'b0;
    #1;
    chk("dbl_back_run", in_handler, 0);
    chk("dbl_elr_kept", elr, 64'h44);
    pc = 64'h100;
    irq_req = 4'b1010;
    tick;
    irq_req = 4'b0000;
    #1;
    chk("t2_ack1", ExtIAck, 4'b0010);
    tick;
    chk("t2_id1", irq_id, 1);
    chk("t2_elr1", elr, 64'h104);
    chk("t2_no_nest", ExtIRQ, 0);
    eret = 1'b1;
    pc = 64'h200;
    tick;
    eret = 1'b0;
    pc = 64'h300;
    #1;
    chk("t2_ack3", ExtIAck, 4'b1000);
    chk("t2_extirq3", ExtIRQ, 1);
    tick;
    chk("t2_id3", irq_id, 3);
    chk("t2_elr3", elr, 64'h304);
    eret = 1'b1;
    tick;
    eret = 1'b0;
    #1;
    chk("t2_idle", ExtIRQ, 0);
    pc = 64'h80;
    irq_req = 4'b0001;
    tick;
    irq_req = 4'b0000;
    not_an_instr = 1'b1;
    #1;
    chk("t3_exc", exc_taken, 1);
    chk("t3_noack", ExtIAck, 0);
    chk("t3_noirq", ExtIRQ, 0);
    tick;
    not_an_instr = 1'b0;
    #1;
    chk("t3_esr", esr, 2);
    chk("t3_elr", elr, 64'h80);
    eret = 1'b1;
    tick;
    eret = 1'b0;
    #1;
    chk("t3_still_pend", ExtIAck, 4'b0001);
    tick;
    chk("t3_id", irq_id, 0);
    eret = 1'b1;
    tick;
    eret = 1'b0;
    pc = 64'h10;
    eret = 1'b1;
    #1;
    chk("t4_exc", exc_taken, 1);
    chk("t4_eret_taken", eret_taken, 0);
    tick;
    eret = 1'b0;
    #1;
    chk("t4_esr", esr, 2);
    chk("t4_elr", elr, 64'h10);
    chk("t4_hnd", in_handler, 1);
    eret = 1'b1;
    tick;
    eret = 1'b0;
    irq_mask = 4'b0000;
    irq_req = 4'b0001;
    tick;
    irq_req = 4'b0000;
    #1;
    chk("t6_masked_irq", ExtIRQ, 0);
    chk("t6_masked_exc", exc_taken, 0);
    tick;
    chk("t6_masked_run", in_handler, 0);
    irq_mask = 4'b0001;
    pc = 64'h500;
    tick;
    chk("t6_hnd", in_handler, 1);
    chk("t6_id", irq_id, 0);
    chk("t6_elr", elr, 64'h504);
    chk("t6_esr", esr, 1);
    eret = 1'b1;
    tick;
    eret = 1'b0;
    irq_mask = 4'hF;
    pc = 64'hFFFFFFFFFFFFFFFC;
    irq_req = 4'b0100;
    tick;
    irq_req = 4'b0000;
    tick;
    chk("wrap_elr", elr, 0);
    irq_req = 4'b0010;
    tick;
    irq_req = 4'b0000;
    not_an_instr = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    chk("ar_hnd", in_handler, 0);
    chk("ar_elr", elr, 0);
    chk("ar_esr", esr, 0);
    chk("ar_id", irq_id, 0);
    chk("ar_exc", exc_taken, 0);
    not_an_instr = 1'b0;
    tick;
    reset = 1'b0;
    #1;
    chk("ar_pend_lost", ExtIRQ, 0);
    tick;
    chk("ar_stay_run", in_handler, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
